spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter width, default 8: bits per transfer, minimum 2.
REQ-002 Parameter halfPeriod, default 4: clk cycles per sclk half-period, minimum 1.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  transfer request, sampled on each clk rising edge.
REQ-006 txData  input  width  word to send, MSB first.
REQ-007 miso  input  1  serial data from peripheral.
REQ-008 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 cs  output  1  chip select, active low.
REQ-010 mosi  output  1  serial data to peripheral.
REQ-011 rxData  output  width  last complete received word.
REQ-012 busy  output  1  high while a transfer is in progress.
REQ-013 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-014 States SHALL be IDLE, LEAD, HIGH, LOW, TRAIL. All outputs SHALL be registered.
REQ-015 IDLE: start=1 SHALL latch txData into the shift register, drive cs=0, busy=1 and mosi=txData[width-1], and enter LEAD.
REQ-016 IDLE with start=0: cs=1, sclk=0, busy=0, mosi holds its last value.
REQ-017 A half-period counter SHALL count halfPeriod clk cycles in each of LEAD, HIGH, LOW and TRAIL.
REQ-018 LEAD to HIGH: drive sclk=1 and shift the miso sample into the receive register LSB.
REQ-019 HIGH to LOW: drive sclk=0 and present the next tx bit on mosi, when fewer than width bits have been sampled.
REQ-020 HIGH to TRAIL: taken after the width-th sample instead of LOW; drive sclk=0 and leave mosi unchanged.
REQ-021 LOW to HIGH: same actions as REQ-018.
REQ-022 TRAIL to IDLE: drive cs=1 and busy=0, load rxData with the receive register, and pulse done=1 for exactly one cycle.
REQ-023 A transfer SHALL span (2*width+1)*halfPeriod cycles of cs=0 and produce exactly width sclk rising edges.
REQ-024 start while busy=1 SHALL be ignored; it is neither queued nor latched, and txData changes mid-transfer have no effect.
REQ-025 start asserted in the same cycle done pulses SHALL be ignored; a new transfer begins no earlier than the following cycle.
REQ-026 rxData SHALL change only on done; it holds its value between transfers.
REQ-027 The bit counter SHALL be ceil(log2(width+1)) bits wide and SHALL not wrap within a transfer.

Reset
REQ-028 While rst_n=0, outputs SHALL take cs=1, sclk=0, mosi=0, busy=0, done=0 and rxData=0; the state SHALL be IDLE and all counters 0, asynchronously.
REQ-029 Reset mid-transfer SHALL abort the transfer immediately, with no done pulse and no rxData update.
REQ-030 After rst_n rises, the first start is accepted on the next clk edge.

Configuration
REQ-031 SPI_MASTER_MISO_SYNC_EN defined: miso SHALL pass through a two-flop synchronizer before sampling, and halfPeriod SHALL be at least 3.
REQ-032 SPI_MASTER_MISO_SYNC_EN undefined: miso SHALL be sampled directly, and the REQ-023 timing is unchanged in both builds.

Verification
REQ-033 Bench: width=8, halfPeriod=4, txData=8'hA5, miso looped to mosi, one start pulse -> mosi bits 1,0,1,0,0,1,0,1; 8 sclk rises; cs low 68 cycles; done once; rxData=8'hA5.
REQ-034 Bench: miso driven from a model peripheral returning 8'h3C (changes on sclk falling edge) -> rxData=8'h3C, with and without SPI_MASTER_MISO_SYNC_EN.
REQ-035 Bench: start held high continuously -> back-to-back transfers, cs high at least 1 cycle between them, one done per transfer.
REQ-036 Bench: second start pulse at cycle 20 of a transfer -> ignored; exactly one done; rxData from the first transfer only.
REQ-037 Bench: rst_n=0 at cycle 30 of a transfer -> cs=1 and sclk=0 within the reset, no done, rxData=0; a following transfer of 8'hFF completes correctly.
REQ-038 Bench: halfPeriod=1, width=2, txData=2'b10 -> cs low 5 cycles, sclk pattern 0,1,0,1,0, done once.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: one word per start request, MSB first, full duplex.
// Define SPI_MASTER_MISO_SYNC_EN to add a two-flop miso synchronizer (needs halfPeriod >= 3).
module spi_master #(
  parameter int width      = 8,
  parameter int halfPeriod = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] txData,
  input  logic             miso,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  output logic [width-1:0] rxData,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(width + 1);
  localparam int HW = (halfPeriod > 1) ? $clog2(halfPeriod) : 1;
  localparam logic [HW-1:0] HP_LAST  = HW'(halfPeriod - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(width);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t           state, state_nx;
  logic [HW-1:0]    hp_cnt, hp_cnt_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [width-1:0] tx_sh, tx_sh_nx;
  logic [width-1:0] rx_sh, rx_sh_nx;
  logic [width-1:0] rx_data_nx;
  logic             sclk_nx, cs_nx, mosi_nx, busy_nx, done_nx;
  logic             miso_s;
  logic             hp_end;
  logic             accept;

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_q;

  // The two-cycle lag is absorbed by the half-period wait before each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_q <= '0;
    else        miso_q <= {miso_q[0], miso};
  end

  assign miso_s = miso_q[1];
`else
  assign miso_s = miso;
`endif

  assign hp_end = (hp_cnt == HP_LAST);
  // A request coinciding with the done pulse is dropped.
  assign accept = start && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: defaulting every comb output first prevents latch inference.
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LEAD;
      LEAD:    if (hp_end) state_nx = HIGH;
      HIGH:    if (hp_end) state_nx = (bit_cnt == BIT_LAST) ? TRAIL : LOW;
      LOW:     if (hp_end) state_nx = HIGH;
      TRAIL:   if (hp_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hp_cnt_nx  = (state == IDLE || hp_end) ? '0 : hp_cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    tx_sh_nx   = tx_sh;
    rx_sh_nx   = rx_sh;
    rx_data_nx = rxData;
    sclk_nx    = sclk;
    cs_nx      = cs;
    mosi_nx    = mosi;
    busy_nx    = busy;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tx_sh_nx   = txData;
          mosi_nx    = txData[width-1];
          cs_nx      = 1'b0;
          busy_nx    = 1'b1;
          bit_cnt_nx = '0;
          rx_sh_nx   = '0;
        end
      end
      LEAD, LOW: begin
        if (hp_end) begin
          sclk_nx    = 1'b1;
          rx_sh_nx   = {rx_sh[width-2:0], miso_s};
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (hp_end) begin
          sclk_nx = 1'b0;
          // After the last sample mosi keeps the final bit through TRAIL.
          if (bit_cnt != BIT_LAST) begin
            tx_sh_nx = {tx_sh[width-2:0], 1'b0};
            mosi_nx  = tx_sh[width-2];
          end
        end
      end
      TRAIL: begin
        if (hp_end) begin
          cs_nx      = 1'b1;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          rx_data_nx = rx_sh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the shift registers, is reset so an
    // aborted transfer leaves no residue.
    if (!rst_n) begin
      hp_cnt  <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rxData  <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      hp_cnt  <= hp_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      tx_sh   <= tx_sh_nx;
      rx_sh   <= rx_sh_nx;
      rxData  <= rx_data_nx;
      sclk    <= sclk_nx;
      cs      <= cs_nx;
      mosi    <= mosi_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master: an 8-bit/4-cycle instance with
// loopback or model peripheral, and a 2-bit/1-cycle instance for the minimum timing.
module tb_spi_master;

  localparam int W  = 8;
  localparam int HP = 4;
  localparam int XFER_LOW = (2 * W + 1) * HP;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         miso;
  logic         sclk, cs, mosi, busy, done;
  logic [W-1:0] rx_data;

  logic         start_s = 1'b0;
  logic [1:0]   tx_s = '0;
  logic         sclk_s, cs_s, mosi_s, busy_s, done_s;
  logic [1:0]   rx_s;

  int total = 0;
  int bad   = 0;

  // peripheral model and monitor state
  logic         loopback = 1'b1;
  logic [W-1:0] per_word = '0;
  logic         per_bit  = 1'b0;
  int           p_idx    = 0;
  logic         prev_cs = 1'b1, prev_sclk = 1'b0;
  int           cs_low_cnt = 0, rise_cnt = 0, done_cnt = 0, fall_cnt = 0;
  int           high_run = 0, min_gap = 1000;
  logic         mosi_q[$];
  int           s_low = 0, s_done = 0;
  logic [4:0]   s_pat = '0;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : per_bit;

  spi_master #(.width(W), .halfPeriod(HP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .txData(tx_data), .miso(miso),
    .sclk(sclk), .cs(cs), .mosi(mosi), .rxData(rx_data), .busy(busy), .done(done)
  );

  spi_master #(.width(2), .halfPeriod(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .txData(tx_s), .miso(mosi_s),
    .sclk(sclk_s), .cs(cs_s), .mosi(mosi_s), .rxData(rx_s), .busy(busy_s), .done(done_s)
  );

  // Peripheral presents its word MSB first, advancing after each sclk fall.
  always @(negedge clk) begin
    if (!cs && prev_cs) begin
      p_idx   = W - 1;
      per_bit = per_word[W-1];
    end else if (!cs && !sclk && prev_sclk && p_idx > 0) begin
      p_idx   = p_idx - 1;
      per_bit = per_word[p_idx];
    end
    if (!cs) cs_low_cnt++;
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      mosi_q.push_back(mosi);
    end
    if (done) done_cnt++;
    if (!cs && prev_cs) begin
      if (fall_cnt > 0 && high_run < min_gap) min_gap = high_run;
      fall_cnt++;
    end
    high_run  = cs ? high_run + 1 : 0;
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  always @(negedge clk) begin
    if (!cs_s) begin
      s_low++;
      s_pat = {s_pat[3:0], sclk_s};
    end
    if (done_s) s_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((busy || !cs) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, k < budget, 1);
    tick(2);
  endtask

  function automatic logic [W-1:0] mosi_word(input int from);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++)
      if (from + i < mosi_q.size()) w = {w[W-2:0], mosi_q[from + i]};
    return w;
  endfunction

  // One transfer; expectations come from the word sent and the peripheral's word.
  task automatic do_xfer(input string tag, input logic [W-1:0] tx, input logic lb,
                         input logic [W-1:0] pw);
    int d0 = done_cnt, c0 = cs_low_cnt, r0 = rise_cnt, q0 = mosi_q.size();
    loopback = lb;
    per_word = pw;
    tx_data  = tx;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_idle(tag, 200);
    check({tag, "_rx"},    rx_data, lb ? tx : pw);
    check({tag, "_mosi"},  mosi_word(q0), tx);
    check({tag, "_done"},  done_cnt - d0, 1);
    check({tag, "_cslow"}, cs_low_cnt - c0, XFER_LOW);
    check({tag, "_rises"}, rise_cnt - r0, W);
  endtask

  initial begin
    int d0, f0, c0, q0;
    logic [W-1:0] t1;

    tick(2);
    check("rst_cs",   cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx",   rx_data, 0);
    rst_n = 1'b1;
    tick(2);

    // Minimum configuration: width=2, halfPeriod=1.
    tx_s    = 2'b10;
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    for (int k = 0; k < 20 && busy_s; k++) tick(1);
    tick(2);
    check("small_cslow", s_low, 5);
    check("small_sclk",  s_pat, 5'b01010);
    check("small_done",  s_done, 1);
    check("small_rx",    rx_s, 2'b10);

    do_xfer("loop_a5", 8'hA5, 1'b1, 8'h00);
    do_xfer("per_3c", W'($urandom), 1'b0, 8'h3C);
    for (int i = 0; i < 4; i++)
      do_xfer($sformatf("rand%0d", i), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom));

    // Second request and txData change mid-transfer are ignored.
    loopback = 1'b1;
    t1 = W'($urandom);
    d0 = done_cnt; c0 = cs_low_cnt; q0 = mosi_q.size();
    tx_data = t1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(19);
    tx_data = ~t1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("ign", 200);
    tick(80);
    check("ign_done",  done_cnt - d0, 1);
    check("ign_rx",    rx_data, t1);
    check("ign_mosi",  mosi_word(q0), t1);
    check("ign_cslow", cs_low_cnt - c0, XFER_LOW);

    // start held high: back-to-back transfers, one done each.
    t1 = W'($urandom);
    tx_data = t1;
    d0 = done_cnt; f0 = fall_cnt;
    start = 1'b1;
    tick(3 * (XFER_LOW + 2));
    start = 1'b0;
    wait_idle("b2b", 200);
    check("b2b_pairs", done_cnt - d0, fall_cnt - f0);
    check("b2b_many",  (done_cnt - d0) >= 3, 1);
    check("b2b_gap",   min_gap >= 1, 1);
    check("b2b_rx",    rx_data, t1);

    // Reset mid-transfer aborts without done; next transfer is clean.
    tx_data = W'($urandom);
    d0 = done_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(29);
    rst_n = 1'b0;
    #1;
    check("abort_cs",   cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_rx",   rx_data, 0);
    tick(3);
    check("abort_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    tx_data = 8'hFF;
    d0 = done_cnt; c0 = cs_low_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("post_rst_accept", cs, 0);
    wait_idle("post_rst", 200);
    check("post_rst_rx",    rx_data, 8'hFF);
    check("post_rst_done",  done_cnt - d0, 1);
    check("post_rst_cslow", cs_low_cnt - c0, XFER_LOW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
